// File: rtl/div_unit_mc_pkg.sv
// Shared encodings for the multi-cycle divider: ALU op codes common to the
// ALU/control unit, the divider FSM state encoding and a decode helper.
package div_unit_mc_pkg;

   // ALU op codes for the RV32M divide group (shared with ALU and control unit)
   localparam logic [4:0] OPDIV  = 5'b01100;
   localparam logic [4:0] OPDIVU = 5'b01101;
   localparam logic [4:0] OPREM  = 5'b01110;
   localparam logic [4:0] OPREMU = 5'b01111;

   // Data-path zero, shared with the ALU writeback logic
   localparam logic [31:0] ZERO = 32'h0000_0000;

   // Divider FSM states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } div_state_t;

   // True for any of the four divide/remainder op codes
   function automatic logic is_div_op(input logic [4:0] op);
      return (op == OPDIV) || (op == OPDIVU) || (op == OPREM) || (op == OPREMU);
   endfunction

endpackage

// File: rtl/div_unit_mc_div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, try to
// subtract the divisor, keep the difference when it does not borrow and
// shift the resulting quotient bit into quo.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   // Trial subtraction; the partial remainder is WIDTH+1 bits after the shift
   always_comb begin
      shifted  = {rem, quo[WIDTH-1]};
      borrow   = (shifted < {1'b0, divisor});
      diff     = shifted[WIDTH-1:0] - divisor;
      rem_next = borrow ? shifted[WIDTH-1:0] : diff;
      quo_next = {quo[WIDTH-2:0], ~borrow};
   end

endmodule

// File: rtl/div_unit_mc.sv
// Multi-cycle iterative divider for RV32M DIV/DIVU/REM/REMU.
// Handshake (valid/ready): a request is taken on a rising clock edge where
// iStart=1, oReady=1 and iFlush=0. oReady is high exactly while the FSM is
// idle (including the oDone cycle, so back-to-back requests are taken).
// oDone pulses for one cycle per completed request and oResult holds the
// value until the next completion. Requests while busy are dropped.
// Divide-by-zero, signed overflow and non-divide op codes bypass the
// iteration and complete one edge after acceptance.
module div_unit_mc
   import div_unit_mc_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iStart,
   input  logic [4:0]       iControlSignal,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   input  logic             iFlush,
   output logic             oReady,
   output logic             oDone,
   output logic [WIDTH-1:0] oResult,
   output div_state_t       dbg_state
);

   localparam int            CW    = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] ITERS = CW'(WIDTH);

   div_state_t       state;
   div_state_t       state_next;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] special_res_q;
   logic             is_rem_q;
   logic             neg_quo_q;
   logic             neg_rem_q;
   logic             special_q;

   logic             fsm_ready;
   logic             done_set;
   logic             accept;
   logic             op_signed;
   logic             op_rem;
   logic             op_is_div;
   logic             sign_a;
   logic             sign_b;
   logic             div_zero;
   logic             sgn_ovf;
   logic             special;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH-1:0] special_val;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;
   logic [WIDTH-1:0] fixed_res;

   // Request decode: operand magnitudes and special-case detection
   always_comb begin
      op_is_div   = is_div_op(iControlSignal);
      op_signed   = (iControlSignal == OPDIV) || (iControlSignal == OPREM);
      op_rem      = (iControlSignal == OPREM) || (iControlSignal == OPREMU);
      sign_a      = op_signed & iA[WIDTH-1];
      sign_b      = op_signed & iB[WIDTH-1];
      abs_a       = sign_a ? (~iA + 1'b1) : iA;
      abs_b       = sign_b ? (~iB + 1'b1) : iB;
      div_zero    = (iB == '0);
      sgn_ovf     = op_signed && (iA == {1'b1, {(WIDTH-1){1'b0}}}) && (iB == '1);
      special     = ~op_is_div | div_zero | sgn_ovf;
      special_val = '0;
      if (!op_is_div) begin
         special_val = '0;
      end else if (div_zero) begin
         special_val = op_rem ? iA : '1;
      end else if (sgn_ovf) begin
         special_val = op_rem ? '0 : iA;
      end
      accept = iStart & fsm_ready & ~iFlush;
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dvs_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   // Sign correction of the unsigned quotient/remainder
   always_comb begin
      if (is_rem_q) begin
         fixed_res = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
      end else begin
         fixed_res = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
      end
   end

   // FSM state register
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic; flush overrides everything
   always_comb begin
      state_next = state;
      if (iFlush) begin
         state_next = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (accept) state_next = special ? S_FIX : S_CALC;
            S_CALC: if (count == CW'(1)) state_next = S_FIX;
            S_FIX:  state_next = S_IDLE;
            default: state_next = S_IDLE;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      fsm_ready = (state == S_IDLE);
      done_set  = (state == S_FIX) && !iFlush;
      oReady    = fsm_ready;
      dbg_state = state;
   end

   // Operand capture on accept, one restoring step per CALC cycle
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         count         <= '0;
         rem_q         <= '0;
         quo_q         <= '0;
         dvs_q         <= '0;
         special_res_q <= '0;
         is_rem_q      <= 1'b0;
         neg_quo_q     <= 1'b0;
         neg_rem_q     <= 1'b0;
         special_q     <= 1'b0;
      end else if (accept) begin
         count         <= ITERS;
         rem_q         <= '0;
         quo_q         <= abs_a;
         dvs_q         <= abs_b;
         special_res_q <= special_val;
         is_rem_q      <= op_rem;
         neg_quo_q     <= sign_a ^ sign_b;
         neg_rem_q     <= sign_a;
         special_q     <= special;
      end else if ((state == S_CALC) && !iFlush) begin
         count <= count - 1'b1;
         rem_q <= step_rem;
         quo_q <= step_quo;
      end
   end

   // Result register and single-cycle completion pulse
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         oDone   <= 1'b0;
         oResult <= '0;
      end else begin
         oDone <= done_set;
         if (done_set) begin
            oResult <= special_q ? special_res_q : fixed_res;
         end
      end
   end

endmodule

// File: tb/tb_div_unit_mc.sv
// Directed bench for div_unit_mc: vector table, multi-cycle corner
// sequences (flush, busy start, back-to-back, reset) and a short random run.
module tb_div_unit_mc;
   import div_unit_mc_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [4:0]  ctrl;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        ready;
   logic        done;
   logic [31:0] result;
   div_state_t  state_dbg;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[16];

   div_unit_mc #(.WIDTH(32)) dut (
      .iCLK           (clk),
      .iRST           (rst_n),
      .iStart         (start),
      .iControlSignal (ctrl),
      .iA             (a),
      .iB             (b),
      .iFlush         (flush),
      .oReady         (ready),
      .oDone          (done),
      .oResult        (result),
      .dbg_state      (state_dbg)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // present a request for one cycle; returns at the negedge after acceptance
   task automatic start_op(input logic [4:0] op, input logic [31:0] opa, input logic [31:0] opb);
      @(negedge clk);
      start = 1'b1;
      ctrl  = op;
      a     = opa;
      b     = opb;
      @(negedge clk);
      start = 1'b0;
   endtask

   // wait for oDone; cyc0 is the number of cycles already elapsed since accept
   task automatic wait_done(input int cyc0, output logic [31:0] res, output int lat);
      int cyc;
      cyc = cyc0;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout waited=%0d cycles required=oDone", cyc);
      end
      res = result;
      lat = cyc - 1;
   endtask

   task automatic run_check(input string name, input logic [4:0] op, input logic [31:0] opa,
                            input logic [31:0] opb, input logic [31:0] exp, input int exp_lat);
      logic [31:0] res;
      int lat;
      start_op(op, opa, opb);
      wait_done(1, res, lat);
      check32({name, "_result"}, res, exp);
      check_int({name, "_latency"}, lat, exp_lat);
      @(negedge clk);
      check32({name, "_done_pulse"}, {31'b0, done}, 32'd0);
   endtask

   function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
      logic signed [31:0] sx;
      logic signed [31:0] sy;
      logic ovf;
      sx  = x;
      sy  = y;
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      case (op)
         OPDIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         OPREMU: return (y == 0) ? x : x % y;
         OPDIV:  return (y == 0) ? 32'hFFFF_FFFF : (ovf ? x : 32'(sx / sy));
         OPREM:  return (y == 0) ? x : (ovf ? 32'h0 : 32'(sx % sy));
         default: return 32'h0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
      logic sgn;
      sgn = (op == OPDIV) || (op == OPREM);
      if (!is_div_op(op)) return 1;
      if (y == 0) return 1;
      if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   initial begin
      logic [31:0] res;
      int lat;
      int done_seen;
      logic [4:0] ops[4];

      vecs[0]  = '{OPDIV,  32'd20,         32'd3,          32'd6,          33};
      vecs[1]  = '{OPREM,  32'd20,         32'd3,          32'd2,          33};
      vecs[2]  = '{OPDIVU, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  33};
      vecs[3]  = '{OPDIV,  32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFA,  33};
      vecs[4]  = '{OPREM,  32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFE,  33};
      vecs[5]  = '{OPREM,  32'd20,         32'hFFFF_FFFD,  32'd2,          33};
      vecs[6]  = '{OPDIV,  32'd20,         32'hFFFF_FFFD,  32'hFFFF_FFFA,  33};
      vecs[7]  = '{OPDIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
      vecs[8]  = '{OPREMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};
      vecs[9]  = '{OPREMU, 32'd100,        32'd7,          32'd2,          33};
      vecs[10] = '{OPDIVU, 32'd7,          32'd0,          32'hFFFF_FFFF,  1};
      vecs[11] = '{OPREMU, 32'd7,          32'd0,          32'd7,          1};
      vecs[12] = '{OPDIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
      vecs[13] = '{OPREM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
      vecs[14] = '{OPREM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
      vecs[15] = '{5'b00000, 32'd20,       32'd3,          32'd0,          1};

      // reset
      rst_n = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      ctrl  = 5'd0;
      a     = 32'd0;
      b     = 32'd0;
      repeat (3) @(negedge clk);
      check32("reset_ready", {31'b0, ready}, 32'd1);
      check32("reset_done", {31'b0, done}, 32'd0);
      check32("reset_result", result, 32'd0);
      check32("reset_state", {30'b0, state_dbg}, {30'b0, S_IDLE});
      rst_n = 1'b1;

      // vector table
      for (int i = 0; i < 16; i++) begin
         run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      end

      // busy start ignored: DIV 100,7 with a stray REMU request mid-calculation
      start_op(OPDIV, 32'd100, 32'd7);
      repeat (4) @(negedge clk);
      check32("busy_ready_low", {31'b0, ready}, 32'd0);
      start = 1'b1;
      ctrl  = OPREMU;
      a     = 32'd5;
      b     = 32'd0;
      @(negedge clk);
      start = 1'b0;
      wait_done(6, res, lat);
      check32("busy_result", res, 32'd14);
      check_int("busy_latency", lat, 33);
      @(negedge clk);
      check32("busy_no_second_done", {31'b0, done}, 32'd0);
      check32("busy_ready_after", {31'b0, ready}, 32'd1);

      // flush on cycle 10 of CALC: no done, result keeps 14
      start_op(OPDIV, 32'd20, 32'd3);
      repeat (9) @(negedge clk);
      check32("flush_pre_state", {30'b0, state_dbg}, {30'b0, S_CALC});
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check32("flush_ready", {31'b0, ready}, 32'd1);
      check32("flush_done", {31'b0, done}, 32'd0);
      check32("flush_result_held", result, 32'd14);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check_int("flush_no_late_done", done_seen, 0);

      // flush wins over simultaneous start
      @(negedge clk);
      start = 1'b1;
      flush = 1'b1;
      ctrl  = OPDIV;
      a     = 32'd20;
      b     = 32'd3;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      check32("flush_start_state", {30'b0, state_dbg}, {30'b0, S_IDLE});

      // flush in FIX of a special-case request
      start_op(OPDIVU, 32'd9, 32'd0);
      check32("fixflush_state", {30'b0, state_dbg}, {30'b0, S_FIX});
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check32("fixflush_done", {31'b0, done}, 32'd0);
      check32("fixflush_result_held", result, 32'd14);

      // back-to-back: second request in the oDone cycle
      start_op(OPDIV, 32'd20, 32'd3);
      wait_done(1, res, lat);
      check32("b2b_first_result", res, 32'd6);
      check32("b2b_ready_in_done", {31'b0, ready}, 32'd1);
      start = 1'b1;
      ctrl  = OPREM;
      a     = 32'hFFFF_FFEC;
      b     = 32'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done(1, res, lat);
      check32("b2b_second_result", res, 32'hFFFF_FFFE);
      check_int("b2b_second_latency", lat, 33);

      // reset mid-calculation
      start_op(OPDIV, 32'd20, 32'd3);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check32("midrst_ready", {31'b0, ready}, 32'd1);
      check32("midrst_done", {31'b0, done}, 32'd0);
      check32("midrst_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_check("after_rst", OPDIV, 32'd100, 32'd7, 32'd14, 33);

      // random operands against the reference model
      ops[0] = OPDIV;
      ops[1] = OPDIVU;
      ops[2] = OPREM;
      ops[3] = OPREMU;
      for (int i = 0; i < 30; i++) begin
         logic [4:0]  op;
         logic [31:0] ra;
         logic [31:0] rb;
         int          sel;
         int          elat;
         op  = ops[$urandom_range(0, 3)];
         ra  = $urandom;
         rb  = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) rb = 32'd0;
         if (sel == 1) rb = 32'hFFFF_FFFF;
         if (sel == 2) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end
         if (sel == 3) rb = 32'($urandom_range(1, 20));
         exp_q.push_back(ref_model(op, ra, rb));
         elat = ref_lat(op, ra, rb);
         start_op(op, ra, rb);
         wait_done(1, res, lat);
         check32($sformatf("rand%0d_result", i), res, exp_q.pop_front());
         check_int($sformatf("rand%0d_latency", i), lat, elat);
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
